// File: rtl/hit_resolver.sv
// Resolves accepted attack hits against the defender's shield on frame ticks:
// absorb, shield break or unshielded damage/knockback, plus stun state timing.
module hit_resolver #(
    parameter int SHIELDSTUN_FRAMES = 8,
    parameter int BREAK_FRAMES      = 120,
    parameter int MIN_HITSTUN       = 4,
    parameter int MAX_PERCENT       = 999,
    parameter int KB_SHIFT          = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       respawn,
    input  logic       hit_valid,
    output logic       hit_ready,
    input  logic [7:0] hit_damage,
    input  logic [7:0] hit_knockback,
    input  logic       shield_active,
    input  logic [7:0] shield_value,
    output logic       shield_dmg_valid,
    output logic [7:0] shield_dmg,
    output logic       kb_valid,
    output logic [7:0] kb_out,
    output logic [9:0] percent,
    output logic       in_hitstun,
    output logic       in_shieldstun,
    output logic       shield_lockout
);
    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_HITSTUN    = 2'd1;
    localparam logic [1:0] S_SHIELDSTUN = 2'd2;
    localparam logic [1:0] S_BROKEN     = 2'd3;

    localparam logic [10:0] MAX_P   = 11'(MAX_PERCENT);
    localparam logic [7:0]  SS_CNT  = 8'(SHIELDSTUN_FRAMES);
    localparam logic [7:0]  BRK_CNT = 8'(BREAK_FRAMES);
    localparam logic [7:0]  MIN_HS  = 8'(MIN_HITSTUN);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic [7:0] dmg_q, dmg_d;
    logic [7:0] kbp_q, kbp_d;
    logic [9:0] percent_q, percent_d;
    logic [7:0] kb_out_q, kb_out_d;
    logic [7:0] shield_dmg_q, shield_dmg_d;
    logic       kb_valid_q, kb_valid_d;
    logic       sdv_q, sdv_d;
    logic       ready_q;
    logic       hs_q, ss_q, lock_q;

    logic        shielded_s, absorb_s, resolve_s, accept_s;
    logic [10:0] add_s, sum_s, p_new_s;
    logic [9:0]  kb_sum_s;
    logic [7:0]  kb_s, half_kb_s, stun_s;

    // Resolution arithmetic for the pending hit against the live shield.
    always_comb begin
        shielded_s = shield_active && (state_q != S_BROKEN);
        absorb_s   = shielded_s && (shield_value > dmg_q);
        if (shielded_s) begin
            add_s = {3'b000, dmg_q - shield_value};
        end else begin
            add_s = {3'b000, dmg_q};
        end
        sum_s    = {1'b0, percent_q} + add_s;
        p_new_s  = (sum_s > MAX_P) ? MAX_P : sum_s;
        kb_sum_s = {2'b00, kbp_q} + 10'(p_new_s >> KB_SHIFT);
        kb_s     = (kb_sum_s > 10'd255) ? 8'hFF : kb_sum_s[7:0];
        half_kb_s = kb_s >> 1;
        stun_s   = (half_kb_s < MIN_HS) ? MIN_HS : half_kb_s;
    end

    // Next-state logic: handshake, resolution, countdown, respawn override.
    always_comb begin
        resolve_s    = frame_tick && pend_q;
        accept_s     = hit_valid && ready_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        dmg_d        = dmg_q;
        kbp_d        = kbp_q;
        percent_d    = percent_q;
        kb_out_d     = kb_out_q;
        shield_dmg_d = shield_dmg_q;
        kb_valid_d   = 1'b0;
        sdv_d        = 1'b0;

        if (respawn) begin
            state_d   = S_IDLE;
            cnt_d     = 8'd0;
            pend_d    = 1'b0;
            percent_d = 10'd0;
        end else if (resolve_s) begin
            pend_d = 1'b0;
            if (absorb_s) begin
                shield_dmg_d = dmg_q;
                sdv_d        = 1'b1;
                state_d      = S_SHIELDSTUN;
                cnt_d        = SS_CNT;
            end else if (shielded_s) begin
                shield_dmg_d = shield_value;
                sdv_d        = 1'b1;
                percent_d    = p_new_s[9:0];
                state_d      = S_BROKEN;
                cnt_d        = BRK_CNT;
            end else begin
                percent_d  = p_new_s[9:0];
                kb_out_d   = kb_s;
                kb_valid_d = 1'b1;
                state_d    = S_HITSTUN;
                cnt_d      = stun_s;
            end
        end else begin
            if (accept_s) begin
                pend_d = 1'b1;
                dmg_d  = hit_damage;
                kbp_d  = hit_knockback;
            end else begin
                pend_d = pend_q;
            end
            // A state entered with count N ends on its Nth tick.
            if (frame_tick && (state_q != S_IDLE)) begin
                if (cnt_q <= 8'd1) begin
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            pend_q       <= 1'b0;
            dmg_q        <= 8'd0;
            kbp_q        <= 8'd0;
            percent_q    <= 10'd0;
            kb_out_q     <= 8'd0;
            shield_dmg_q <= 8'd0;
            kb_valid_q   <= 1'b0;
            sdv_q        <= 1'b0;
            ready_q      <= 1'b1;
            hs_q         <= 1'b0;
            ss_q         <= 1'b0;
            lock_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            dmg_q        <= dmg_d;
            kbp_q        <= kbp_d;
            percent_q    <= percent_d;
            kb_out_q     <= kb_out_d;
            shield_dmg_q <= shield_dmg_d;
            kb_valid_q   <= kb_valid_d;
            sdv_q        <= sdv_d;
            ready_q      <= !pend_d;
            hs_q         <= (state_d == S_HITSTUN);
            ss_q         <= (state_d == S_SHIELDSTUN);
            lock_q       <= (state_d == S_BROKEN);
        end
    end

    assign hit_ready        = ready_q;
    assign shield_dmg_valid = sdv_q;
    assign shield_dmg       = shield_dmg_q;
    assign kb_valid         = kb_valid_q;
    assign kb_out           = kb_out_q;
    assign percent          = percent_q;
    assign in_hitstun       = hs_q;
    assign in_shieldstun    = ss_q;
    assign shield_lockout   = lock_q;
endmodule

// File: tb/tb_hit_resolver.sv
// Directed bench for hit_resolver: hand-computed expectations checked with
// immediate assertions after each step.
module tb_hit_resolver;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       respawn = 1'b0;
    logic       hit_valid = 1'b0;
    logic       hit_ready;
    logic [7:0] hit_damage = 8'd0;
    logic [7:0] hit_knockback = 8'd0;
    logic       shield_active = 1'b0;
    logic [7:0] shield_value = 8'd0;
    logic       shield_dmg_valid;
    logic [7:0] shield_dmg;
    logic       kb_valid;
    logic [7:0] kb_out;
    logic [9:0] percent;
    logic       in_hitstun;
    logic       in_shieldstun;
    logic       shield_lockout;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    hit_resolver dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .respawn(respawn),
        .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_damage(hit_damage),
        .hit_knockback(hit_knockback), .shield_active(shield_active),
        .shield_value(shield_value), .shield_dmg_valid(shield_dmg_valid),
        .shield_dmg(shield_dmg), .kb_valid(kb_valid), .kb_out(kb_out),
        .percent(percent), .in_hitstun(in_hitstun), .in_shieldstun(in_shieldstun),
        .shield_lockout(shield_lockout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            cyc();
        end
    endtask

    // Offer a hit on a non-tick cycle, then resolve it on the next tick.
    task automatic hit(input logic [7:0] d, input logic [7:0] k, input logic sa, input logic [7:0] sv);
        hit_damage = d; hit_knockback = k; shield_active = sa; shield_value = sv;
        hit_valid = 1'b1;
        cyc();
        hit_valid = 1'b0;
        tick();
    endtask

    initial begin
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        chk("rst_ready", hit_ready, 1);
        chk("rst_percent", percent, 0);
        chk("rst_kb_out", kb_out, 0);
        chk("rst_shield_dmg", shield_dmg, 0);
        chk("rst_status", {in_hitstun, in_shieldstun, shield_lockout, kb_valid, shield_dmg_valid}, 0);

        // Unshielded hit with a second offer ignored while pending.
        hit_damage = 8'd12; hit_knockback = 8'd20; hit_valid = 1'b1;
        cyc();
        chk("pend_ready_low", hit_ready, 0);
        hit_damage = 8'd99;
        cyc();
        chk("pend_ready_still_low", hit_ready, 0);
        hit_valid = 1'b0;
        tick();
        chk("t1_kb_valid", kb_valid, 1);
        chk("t1_kb_out", kb_out, 21);
        chk("t1_percent", percent, 12);
        chk("t1_hitstun", in_hitstun, 1);
        chk("t1_ready_back", hit_ready, 1);
        cyc();
        chk("t1_kb_pulse_end", kb_valid, 0);
        ticks(9);
        chk("t1_hitstun_9", in_hitstun, 1);
        ticks(1);
        chk("t1_hitstun_10", in_hitstun, 0);
        chk("t1_second_dropped", percent, 12);

        // Absorbed hit.
        hit(8'd30, 8'd40, 1'b1, 8'd200);
        chk("t2_sdv", shield_dmg_valid, 1);
        chk("t2_shield_dmg", shield_dmg, 30);
        chk("t2_no_kb", kb_valid, 0);
        chk("t2_percent", percent, 12);
        chk("t2_shieldstun", in_shieldstun, 1);
        cyc();
        chk("t2_sdv_end", shield_dmg_valid, 0);
        ticks(7);
        chk("t2_ss_7", in_shieldstun, 1);
        ticks(1);
        chk("t2_ss_8", in_shieldstun, 0);

        // Shield break, then an unshielded hit during lockout.
        hit(8'd25, 8'd40, 1'b1, 8'd10);
        chk("t3_sdv", shield_dmg_valid, 1);
        chk("t3_shield_dmg", shield_dmg, 10);
        chk("t3_percent", percent, 27);
        chk("t3_lockout", shield_lockout, 1);
        chk("t3_no_kb", kb_valid, 0);
        ticks(5);
        chk("t3_lockout_held", shield_lockout, 1);
        hit(8'd3, 8'd0, 1'b1, 8'd10);
        chk("t3_lock_drop", shield_lockout, 0);
        chk("t3_hitstun", in_hitstun, 1);
        chk("t3_kb_out", kb_out, 3);
        chk("t3_percent2", percent, 30);

        // Hit accepted on a tick cycle resolves only on the following tick.
        hit_damage = 8'd0; hit_knockback = 8'd0; shield_active = 1'b0;
        hit_valid = 1'b1;
        tick();
        hit_valid = 1'b0;
        chk("tk_not_same", kb_valid, 0);
        chk("tk_pending", hit_ready, 0);
        cyc();
        tick();
        chk("tk_resolved", kb_valid, 1);
        chk("tk_kb_out", kb_out, 3);
        ticks(4);
        chk("tk_hitstun_done", in_hitstun, 0);

        // Percent saturation.
        hit(8'd255, 8'd0, 1'b0, 8'd0);
        hit(8'd255, 8'd0, 1'b0, 8'd0);
        hit(8'd255, 8'd0, 1'b0, 8'd0);
        hit(8'd195, 8'd0, 1'b0, 8'd0);
        chk("sat_990", percent, 990);
        hit(8'd50, 8'd0, 1'b0, 8'd0);
        chk("sat_999", percent, 999);

        // Knockback saturation and long hitstun.
        hit(8'd0, 8'd250, 1'b0, 8'd0);
        chk("kb_sat", kb_out, 255);
        chk("kb_percent", percent, 999);
        ticks(126);
        chk("hs127_held", in_hitstun, 1);
        ticks(1);
        chk("hs127_done", in_hitstun, 0);

        // Respawn mid-hitstun with a hit pending.
        hit(8'd10, 8'd10, 1'b0, 8'd0);
        chk("rsp_pre_hitstun", in_hitstun, 1);
        hit_damage = 8'd7; hit_valid = 1'b1;
        cyc();
        chk("rsp_pending", hit_ready, 0);
        respawn = 1'b1;
        cyc();
        chk("rsp_ready", hit_ready, 1);
        cyc();
        respawn = 1'b0; hit_valid = 1'b0;
        chk("rsp_percent", percent, 0);
        chk("rsp_idle", in_hitstun, 0);
        chk("rsp_not_accepted", hit_ready, 1);
        tick();
        chk("rsp_no_pulse", {kb_valid, shield_dmg_valid}, 0);
        chk("rsp_percent_kept", percent, 0);

        // Asynchronous reset with a hit pending.
        hit(8'd20, 8'd20, 1'b0, 8'd0);
        hit_valid = 1'b1;
        cyc();
        hit_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("ar_ready", hit_ready, 1);
        chk("ar_percent", percent, 0);
        chk("ar_status", {in_hitstun, kb_out}, 0);
        cyc();
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
